// File: rtl/vmx_execute_engine_p_if.sv
// Queue-side bundle of the VMX execute engine: ISA/AEQ pop ports and the EAQ push port.
// master = engine side, slave = queue side.
interface vmx_execute_engine_p_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
);
    logic [31:0]             ISA_FIFO_DATA;
    logic                    ISA_FIFO_EMPTY;
    logic                    ISA_FIFO_RENA;
    logic [LANES*DATA_W-1:0] AEQ_FIFO_DATA;
    logic                    AEQ_FIFO_EMPTY;
    logic                    AEQ_FIFO_RENA;
    logic [LANES*ACC_W-1:0]  EAQ_FIFO_DATA;
    logic                    EAQ_FIFO_FULL;
    logic                    EAQ_FIFO_WENA;

    modport master (
        input  ISA_FIFO_DATA, ISA_FIFO_EMPTY, AEQ_FIFO_DATA, AEQ_FIFO_EMPTY, EAQ_FIFO_FULL,
        output ISA_FIFO_RENA, AEQ_FIFO_RENA, EAQ_FIFO_DATA, EAQ_FIFO_WENA
    );

    modport slave (
        output ISA_FIFO_DATA, ISA_FIFO_EMPTY, AEQ_FIFO_DATA, AEQ_FIFO_EMPTY, EAQ_FIFO_FULL,
        input  ISA_FIFO_RENA, AEQ_FIFO_RENA, EAQ_FIFO_DATA, EAQ_FIFO_WENA
    );
endinterface

// File: rtl/vmx_execute_engine_p.sv
// VMX execute engine: decodes ISA words and runs LANES-wide MAC / element-wise multiply
// over AEQ operand beats, pushing registered per-lane results to the EAQ.
module vmx_execute_engine_p #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sw_rst,
    input  logic                  halt,
    vmx_execute_engine_p_if.master bus,
    output logic                  BUSY,
    output logic                  ERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_LOADW, S_MAC, S_EW, S_WRITE
    } state_t;

    localparam logic [3:0] OP_LOADW = 4'd0;
    localparam logic [3:0] OP_MAC   = 4'd1;
    localparam logic [3:0] OP_EW    = 4'd2;
    localparam logic [3:0] OP_NOP   = 4'd3;
    localparam logic [CNT_W:0] CTR_ONE = {{CNT_W{1'b0}}, 1'b1};

    // Full-precision product, sign- or zero-extended to the accumulator width.
    function automatic logic [ACC_W-1:0] ext_prod(input logic [DATA_W-1:0] w,
                                                  input logic [DATA_W-1:0] d,
                                                  input logic              sgn);
        logic signed [2*DATA_W-1:0] ps;
        logic        [2*DATA_W-1:0] pu;
        ps = (2*DATA_W)'($signed(w)) * (2*DATA_W)'($signed(d));
        pu = (2*DATA_W)'(w) * (2*DATA_W)'(d);
        if (sgn) return ACC_W'(ps);
        return ACC_W'(pu);
    endfunction

    // Accumulation wraps modulo 2^ACC_W by design.
    function automatic logic [ACC_W-1:0] acc_wrap(input logic [ACC_W-1:0] a,
                                                  input logic [ACC_W-1:0] b);
        return a + b;
    endfunction

    state_t                  state_q, state_d;
    logic [3:0]              op_q, op_d;
    logic                    sgn_q, sgn_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W:0]          ctr_q, ctr_d;
    logic [LANES*DATA_W-1:0] w_q, w_d;
    logic [LANES*ACC_W-1:0]  acc_q, acc_d;
    logic [LANES*ACC_W-1:0]  eaq_q, eaq_d;
    logic                    err_q, err_d;
    logic                    isa_rena, aeq_rena, eaq_wena;
    logic                    rst_act;
    logic                    unused_isa_bits;

    assign rst_act         = !rst_n || sw_rst;
    assign unused_isa_bits = ^{bus.ISA_FIFO_DATA[31:8+CNT_W], bus.ISA_FIFO_DATA[7:5]};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sgn_d    = sgn_q;
        cnt_d    = cnt_q;
        ctr_d    = ctr_q;
        w_d      = w_q;
        acc_d    = acc_q;
        eaq_d    = eaq_q;
        err_d    = err_q;
        isa_rena = 1'b0;
        aeq_rena = 1'b0;
        eaq_wena = 1'b0;
        // Reset and halt both suppress every strobe, so the queues never move.
        if (!rst_act && !halt) begin
            case (state_q)
                S_IDLE: if (!bus.ISA_FIFO_EMPTY) begin
                    isa_rena = 1'b1;
                    op_d     = bus.ISA_FIFO_DATA[3:0];
                    sgn_d    = bus.ISA_FIFO_DATA[4];
                    cnt_d    = bus.ISA_FIFO_DATA[8 +: CNT_W];
                    acc_d    = '0;
                    ctr_d    = '0;
                    state_d  = S_DECODE;
                end
                S_DECODE: begin
                    case (op_q)
                        OP_LOADW: state_d = S_LOADW;
                        OP_MAC:   state_d = S_MAC;
                        OP_EW:    state_d = S_EW;
                        OP_NOP:   state_d = S_IDLE;
                        default: begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
                S_LOADW: if (!bus.AEQ_FIFO_EMPTY) begin
                    aeq_rena = 1'b1;
                    w_d      = bus.AEQ_FIFO_DATA;
                    state_d  = S_IDLE;
                end
                S_MAC: if (!bus.AEQ_FIFO_EMPTY) begin
                    aeq_rena = 1'b1;
                    for (int i = 0; i < LANES; i++) begin
                        acc_d[i*ACC_W +: ACC_W] = acc_wrap(acc_q[i*ACC_W +: ACC_W],
                            ext_prod(w_q[i*DATA_W +: DATA_W], bus.AEQ_FIFO_DATA[i*DATA_W +: DATA_W], sgn_q));
                    end
                    ctr_d = ctr_q + CTR_ONE;
                    if (ctr_q == {1'b0, cnt_q}) begin
                        eaq_d   = acc_d;
                        state_d = S_WRITE;
                    end
                end
                S_EW: if (!bus.AEQ_FIFO_EMPTY) begin
                    aeq_rena = 1'b1;
                    for (int i = 0; i < LANES; i++) begin
                        eaq_d[i*ACC_W +: ACC_W] = ext_prod(w_q[i*DATA_W +: DATA_W],
                            bus.AEQ_FIFO_DATA[i*DATA_W +: DATA_W], sgn_q);
                    end
                    ctr_d   = ctr_q + CTR_ONE;
                    state_d = S_WRITE;
                end
                S_WRITE: if (!bus.EAQ_FIFO_FULL) begin
                    eaq_wena = 1'b1;
                    // ctr counts beats already consumed, so ctr <= cnt means beats remain.
                    if (op_q == OP_EW && ctr_q <= {1'b0, cnt_q}) state_d = S_EW;
                    else                                        state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_act) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            ctr_q   <= '0;
            w_q     <= '0;
            acc_q   <= '0;
            eaq_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            ctr_q   <= ctr_d;
            w_q     <= w_d;
            acc_q   <= acc_d;
            eaq_q   <= eaq_d;
            err_q   <= err_d;
        end
    end

    assign bus.ISA_FIFO_RENA = isa_rena;
    assign bus.AEQ_FIFO_RENA = aeq_rena;
    assign bus.EAQ_FIFO_WENA = eaq_wena;
    assign bus.EAQ_FIFO_DATA = eaq_q;
    assign BUSY              = (state_q != S_IDLE);
    assign ERR               = err_q;

endmodule
